// File: rtl/tone_sample_generator_pkg.sv
// Shared audio definitions for the tone source, AC97 controller and sample FIFO.
//   SAMPLE_W          : width of one signed audio sample
//   AMPLITUDE_DEFAULT : default positive peak of the square wave
//   tone_state_e      : tone source FSM encodings (idle / run / pending write)
//   tick_div()        : system clocks per sample period
package tone_sample_generator_pkg;

    localparam int unsigned SAMPLE_W = 20;
    localparam logic [SAMPLE_W-1:0] AMPLITUDE_DEFAULT = 20'h3FFFF;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StPend = 2'd2
    } tone_state_e;

    function automatic int unsigned tick_div(input int unsigned clk_freq,
                                             input int unsigned sample_rate);
        return clk_freq / sample_rate;
    endfunction

endpackage

// File: rtl/tone_sample_generator_sample_tick_gen.sv
// Sample-period divider for the tone source.
//   system_clock   in  : clock
//   system_reset_b in  : asynchronous active-low reset
//   clear          in  : hold the divider at 0 (no tick while set)
//   tick           out : one-cycle pulse every TICK_DIV cycles
module tone_sample_generator_sample_tick_gen #(
    parameter int unsigned TICK_DIV = 10
) (
    input  logic system_clock,
    input  logic system_reset_b,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] tick_cnt_q;

    always_ff @(posedge system_clock or negedge system_reset_b) begin
        if (!system_reset_b) begin
            tick_cnt_q <= '0;
        end else if (clear || tick_cnt_q == CNT_LAST) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    assign tick = !clear && (tick_cnt_q == CNT_LAST);

endmodule

// File: rtl/tone_sample_generator.sv
// Square-wave tone source writing one signed sample per sample period into the audio FIFO.
//   system_clock      in  : single clock
//   system_reset_b    in  : asynchronous active-low reset
//   enable            in  : 1 = generate tone, 0 = return to idle and flush pending sample
//   tone_half_period  in  : samples per half-cycle, 0 = silence
//   sample_fifo_full  in  : FIFO cannot accept a write this cycle
//   sample_fifo_wr_en out : write strobe, one cycle per sample
//   sample_fifo_din   out : signed sample
//   dropped_count     out : saturating count of overwritten samples
//   volume            in  : attenuation shift, present only when TONE_VOLUME_EN is defined
module tone_sample_generator
    import tone_sample_generator_pkg::*;
#(
    parameter int unsigned          SYS_CLK_FREQ = 50_000_000,
    parameter int unsigned          SAMPLE_RATE  = 48_000,
    parameter logic [SAMPLE_W-1:0]  AMPLITUDE    = AMPLITUDE_DEFAULT,
    parameter int unsigned          PERIOD_W     = 16
) (
    input  logic                system_clock,
    input  logic                system_reset_b,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] tone_half_period,
    input  logic                sample_fifo_full,
`ifdef TONE_VOLUME_EN
    input  logic [3:0]          volume,
`endif
    output logic                sample_fifo_wr_en,
    output logic [SAMPLE_W-1:0] sample_fifo_din,
    output logic [15:0]         dropped_count
);

    localparam int unsigned TICK_DIV = tick_div(SYS_CLK_FREQ, SAMPLE_RATE);
    localparam logic [SAMPLE_W-1:0] AMP_NEG = ~AMPLITUDE + 1'b1;

    tone_state_e         state_q;
    logic [PERIOD_W-1:0] phase_cnt_q;
    logic                polarity_q;   // 0 = positive half, 1 = negative half
    logic                tick;
    logic                tick_clear;
    logic [PERIOD_W:0]   phase_inc;
    logic                phase_wrap;
    logic                silent;
    logic [SAMPLE_W-1:0] raw_sample;
    logic [SAMPLE_W-1:0] next_sample;

    // Divider only runs while the FSM is active and enable is held.
    assign tick_clear = (state_q == StIdle) || !enable;

    tone_sample_generator_sample_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .system_clock   (system_clock),
        .system_reset_b (system_reset_b),
        .clear          (tick_clear),
        .tick           (tick)
    );

    always_comb begin
        silent     = (tone_half_period == '0);
        phase_inc  = {1'b0, phase_cnt_q} + 1'b1;
        // >= so shrinking the half period mid-tone toggles on the next tick.
        phase_wrap = (phase_inc >= {1'b0, tone_half_period});
        raw_sample = silent ? '0 : (polarity_q ? AMP_NEG : AMPLITUDE);
`ifdef TONE_VOLUME_EN
        next_sample = $unsigned($signed(raw_sample) >>> volume);
`else
        next_sample = raw_sample;
`endif
    end

    // Write is gated by enable so a flush cycle never emits the pending sample.
    assign sample_fifo_wr_en = (state_q == StPend) && !sample_fifo_full && enable;

    always_ff @(posedge system_clock or negedge system_reset_b) begin
        if (!system_reset_b) begin
            state_q         <= StIdle;
            phase_cnt_q     <= '0;
            polarity_q      <= 1'b0;
            sample_fifo_din <= '0;
            dropped_count   <= '0;
        end else if (!enable) begin
            state_q     <= StIdle;
            phase_cnt_q <= '0;
            polarity_q  <= 1'b0;
        end else begin
            if (tick) begin
                sample_fifo_din <= next_sample;
                if (silent) begin
                    phase_cnt_q <= '0;
                end else if (phase_wrap) begin
                    phase_cnt_q <= '0;
                    polarity_q  <= !polarity_q;
                end else begin
                    phase_cnt_q <= phase_inc[PERIOD_W-1:0];
                end
            end

            unique case (state_q)
                StIdle: state_q <= StRun;
                StRun: begin
                    if (tick) begin
                        state_q <= StPend;
                    end
                end
                StPend: begin
                    if (tick) begin
                        // New sample replaces din; it is a drop only if the old one never left.
                        state_q <= StPend;
                        if (sample_fifo_full && dropped_count != 16'hFFFF) begin
                            dropped_count <= dropped_count + 1'b1;
                        end
                    end else if (!sample_fifo_full) begin
                        state_q <= StRun;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_tone_sample_generator.sv
module tb_tone_sample_generator;

    logic        system_clock;
    logic        system_reset_b;
    logic        enable;
    logic [15:0] tone_half_period;
    logic        sample_fifo_full;
    logic        sample_fifo_wr_en;
    logic [19:0] sample_fifo_din;
    logic [15:0] dropped_count;
`ifdef TONE_VOLUME_EN
    logic [3:0]  volume;
`endif

    int checks;
    int fails;
    int cyc;
    int last_wr_cyc;
    bit gap_check;
    logic [19:0] exp_q[$];

    tone_sample_generator #(
        .SYS_CLK_FREQ (1000),
        .SAMPLE_RATE  (100)
    ) dut (
        .system_clock      (system_clock),
        .system_reset_b    (system_reset_b),
        .enable            (enable),
        .tone_half_period  (tone_half_period),
        .sample_fifo_full  (sample_fifo_full),
`ifdef TONE_VOLUME_EN
        .volume            (volume),
`endif
        .sample_fifo_wr_en (sample_fifo_wr_en),
        .sample_fifo_din   (sample_fifo_din),
        .dropped_count     (dropped_count)
    );

    initial system_clock = 1'b0;
    always #5 system_clock = ~system_clock;

    always @(posedge system_clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected sample for every write strobe.
    always @(negedge system_clock) begin
        if (system_reset_b && sample_fifo_wr_en) begin
            checks++;
            if (sample_fifo_full) begin
                fails++;
                $display("FAIL wr_while_full: wr_en=1 full=1 expected wr_en=0");
            end
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_write: din=%h expected no write", sample_fifo_din);
            end else begin
                check("din", sample_fifo_din, exp_q.pop_front());
            end
            if (gap_check && last_wr_cyc >= 0) begin
                check("write_gap", 20'(cyc - last_wr_cyc), 20'd10);
            end
            last_wr_cyc = cyc;
        end
    end

    // Returns at the first rising edge after the last expected write was seen.
    task automatic wait_empty(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge system_clock);
            if (exp_q.size() == 0) begin
                #1;
                return;
            end
        end
        checks++;
        fails++;
        $display("FAIL timeout: %0d samples outstanding expected 0", exp_q.size());
        exp_q.delete();
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge system_clock);
        #1;
    endtask

    initial begin
        checks = 0;
        fails = 0;
        cyc = 0;
        last_wr_cyc = -1;
        gap_check = 1'b0;
        system_reset_b = 1'b0;
        enable = 1'b0;
        tone_half_period = 16'd2;
        sample_fifo_full = 1'b0;
`ifdef TONE_VOLUME_EN
        volume = 4'd0;
`endif
        cycles(3);
        check("reset_wr_en", 20'(sample_fifo_wr_en), 20'd0);
        check("reset_din", sample_fifo_din, 20'h0);
        check("reset_dropped", 20'(dropped_count), 20'd0);

        // 1: steady tone, half period 2
        system_reset_b = 1'b1;
        cycles(1);
        gap_check = 1'b1;
        enable = 1'b1;
        exp_q.push_back(20'h3FFFF);
        exp_q.push_back(20'h3FFFF);
        exp_q.push_back(20'hC0001);
        exp_q.push_back(20'hC0001);
        wait_empty(80);
        gap_check = 1'b0;

        // 2: FIFO full across three ticks; only the last sample survives
        sample_fifo_full = 1'b1;
        cycles(30);
        check("dropped_while_full", 20'(dropped_count), 20'd2);
        exp_q.push_back(20'hC0001);
        sample_fifo_full = 1'b0;
        wait_empty(20);
        check("dropped_after", 20'(dropped_count), 20'd2);

        // 3: silence, then half period 1 resumes from the held polarity
        tone_half_period = 16'd0;
        exp_q.push_back(20'h00000);
        exp_q.push_back(20'h00000);
        wait_empty(40);
        tone_half_period = 16'd1;
        exp_q.push_back(20'hC0001);
        exp_q.push_back(20'h3FFFF);
        exp_q.push_back(20'hC0001);
        wait_empty(50);

        // 4: drop enable while pending behind a full FIFO
        tone_half_period = 16'd2;
        sample_fifo_full = 1'b1;
        cycles(10);
        enable = 1'b0;
        check("flush_wr_en", 20'(sample_fifo_wr_en), 20'd0);
        cycles(1);
        sample_fifo_full = 1'b0;
        cycles(3);
        check("dropped_kept", 20'(dropped_count), 20'd2);
        enable = 1'b1;
        exp_q.push_back(20'h3FFFF);
        exp_q.push_back(20'h3FFFF);
        exp_q.push_back(20'hC0001);
        wait_empty(60);

        // 5: asynchronous reset while pending
        sample_fifo_full = 1'b1;
        cycles(10);
        #2;
        system_reset_b = 1'b0;
        #1;
        check("arst_wr_en", 20'(sample_fifo_wr_en), 20'd0);
        check("arst_din", sample_fifo_din, 20'h0);
        check("arst_dropped", 20'(dropped_count), 20'd0);
        sample_fifo_full = 1'b0;
        cycles(2);
        system_reset_b = 1'b1;

`ifdef TONE_VOLUME_EN
        // 6: volume attenuation by arithmetic shift
        volume = 4'd2;
        tone_half_period = 16'd1;
        exp_q.push_back(20'h0FFFF);
        exp_q.push_back(20'hF0000);
        exp_q.push_back(20'h0FFFF);
        wait_empty(50);
`endif
        enable = 1'b0;
        cycles(3);
        check("queue_drained", 20'(exp_q.size()), 20'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
